// File: rtl/srv_line_fill.sv
`default_nettype none
// ============================================================================
// srv_line_fill : fetches a 16-byte line word by word from the ROM and returns it
// Revision 1.0
// ============================================================================
module srv_line_fill #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ext_addr_i,
  input  logic                 ext_req_i,
  output logic                 ext_rsp_o,
  output logic [127:0]         ext_data_o,
  output logic [31:0]          rom_addr_o,
  input  logic [31:0]          rom_data_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] fill_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [3:0] c_WAIT_INIT = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_line_base;
  logic [1:0]  r_word_idx;
  logic [3:0]  r_wait;
  logic [95:0] r_line_buf;
  logic        w_word_done;
  logic        w_unused;

  // The byte offset within the line never affects which line is fetched.
  assign w_unused    = ^ext_addr_i[3:0];
  assign w_word_done = (r_state == S_FETCH) && (r_wait == 4'd0);
  assign rom_addr_o  = (r_state == S_FETCH) ? {2'b00, r_line_base, r_word_idx} : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ext_req_i) w_state_nxt = S_FETCH;
      S_FETCH: if (w_word_done && (r_word_idx == 2'd3)) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_base <= '0;
      r_word_idx  <= '0;
      r_wait      <= '0;
      r_line_buf  <= '0;
      ext_rsp_o   <= 1'b0;
      ext_data_o  <= '0;
      busy_o      <= 1'b0;
      fill_cnt_o  <= '0;
    end else begin
      ext_rsp_o <= (w_state_nxt == S_RESP);
      busy_o    <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (ext_req_i) begin
            r_line_base <= ext_addr_i[31:4];
            r_word_idx  <= 2'd0;
            r_wait      <= c_WAIT_INIT;
          end
        end
        S_FETCH: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else if (r_word_idx != 2'd3) begin
            r_line_buf[{r_word_idx, 5'd0} +: 32] <= rom_data_i;
            r_word_idx <= r_word_idx + 2'd1;
            r_wait     <= c_WAIT_INIT;
          end else begin
            // Last word goes straight to the output alongside the buffered three.
            ext_data_o <= {rom_data_i, r_line_buf};
            fill_cnt_o <= fill_cnt_o + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srv_line_fill.sv
`default_nettype none
// ============================================================================
// tb_srv_line_fill : scoreboard bench for srv_line_fill (latency 1 and 3)
// Revision 1.0
// ============================================================================
module tb_srv_line_fill;

  localparam logic [127:0] L0_3  = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] L4_7  = 128'hA0000007_A0000006_A0000005_A0000004;
  localparam logic [127:0] L8_11 = 128'hA000000B_A000000A_A0000009_A0000008;

  typedef struct {
    logic [127:0] data;
    int           cnt;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic         rst_a, req_a, rsp_a, busy_a;
  logic [31:0]  addr_a, rom_addr_a, rom_data_a;
  logic [127:0] data_a;
  logic [1:0]   cnt_a;

  logic         rst_b, req_b, rsp_b, busy_b;
  logic [31:0]  addr_b, rom_addr_b, rom_data_b;
  logic [127:0] data_b;
  logic [15:0]  cnt_b;

  assign rom_data_a = 32'hA000_0000 + rom_addr_a;
  assign rom_data_b = 32'hA000_0000 + rom_addr_b;

  srv_line_fill #(.MEM_LATENCY(1), .CNT_WIDTH(2)) u_dut_a (
    .clk(clk), .rst(rst_a), .ext_addr_i(addr_a), .ext_req_i(req_a),
    .ext_rsp_o(rsp_a), .ext_data_o(data_a), .rom_addr_o(rom_addr_a),
    .rom_data_i(rom_data_a), .busy_o(busy_a), .fill_cnt_o(cnt_a)
  );

  srv_line_fill #(.MEM_LATENCY(3), .CNT_WIDTH(16)) u_dut_b (
    .clk(clk), .rst(rst_b), .ext_addr_i(addr_b), .ext_req_i(req_b),
    .ext_rsp_o(rsp_b), .ext_data_o(data_b), .rom_addr_o(rom_addr_b),
    .rom_data_i(rom_data_b), .busy_o(busy_b), .fill_cnt_o(cnt_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_line", data_a, e.data);
        chk("a_fill_cnt", cnt_a, e.cnt);
        chk("a_rsp_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_line", data_b, e.data);
        chk("b_fill_cnt", cnt_b, e.cnt);
        chk("b_rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle_a();
    int n = 0;
    @(negedge clk);
    while (busy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_timeout", busy_a, 0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    @(negedge clk);
    while (busy_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_timeout", busy_b, 0);
  endtask

  initial begin
    rst_a = 1'b1; req_a = 1'b0; addr_a = '0;
    rst_b = 1'b1; req_b = 1'b0; addr_b = '0;
    repeat (3) @(negedge clk);
    chk("a_rst_rsp", rsp_a, 0);
    chk("a_rst_data", data_a, 0);
    chk("a_rst_rom_addr", rom_addr_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_cnt", cnt_a, 0);
    chk("b_rst_rsp", rsp_b, 0);
    chk("b_rst_data", data_b, 0);
    chk("b_rst_rom_addr", rom_addr_b, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_cnt", cnt_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Single fill, latency 1, offset 8 inside line 1
    @(negedge clk);
    addr_a = 32'h18; req_a = 1'b1;
    qa.push_back('{L4_7, 1, cyc + 5});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_a = 1'b0;
      chk("t1_rom_addr", rom_addr_a, 4 + i);
      chk("t1_busy", busy_a, 1);
    end
    wait_idle_a();
    chk("t1_hold_data", data_a, L4_7);
    chk("t1_hold_cnt", cnt_a, 1);

    // Request held high: three back-to-back fills, one every 6 cycles
    @(negedge clk);
    addr_a = 32'h10; req_a = 1'b1;
    qa.push_back('{L4_7, 2, cyc + 5});
    qa.push_back('{L4_7, 3, cyc + 11});
    qa.push_back('{L4_7, 0, cyc + 17});
    repeat (13) @(negedge clk);
    req_a = 1'b0;
    wait_idle_a();

    // Request pulsed mid-fetch is ignored
    @(negedge clk);
    addr_a = 32'h20; req_a = 1'b1;
    qa.push_back('{L8_11, 1, cyc + 5});
    @(negedge clk);
    req_a = 1'b0;
    chk("t3_busy1", busy_a, 1);
    chk("t3_data_held", data_a, L4_7);
    @(negedge clk);
    addr_a = 32'h40; req_a = 1'b1;
    chk("t3_busy2", busy_a, 1);
    @(negedge clk);
    req_a = 1'b0;
    chk("t3_busy3", busy_a, 1);
    chk("t3_rom_addr", rom_addr_a, 10);
    @(negedge clk);
    chk("t3_busy4", busy_a, 1);
    @(negedge clk);
    chk("t3_busy_resp", busy_a, 1);
    @(negedge clk);
    chk("t3_idle", busy_a, 0);
    repeat (4) @(negedge clk);

    // Reset in the second fetch cycle discards the fill
    addr_a = 32'h0; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("t4_rsp", rsp_a, 0);
    chk("t4_data", data_a, 0);
    chk("t4_rom_addr", rom_addr_a, 0);
    chk("t4_busy", busy_a, 0);
    chk("t4_cnt", cnt_a, 0);
    rst_a = 1'b0;
    repeat (8) @(negedge clk);
    addr_a = 32'h4; req_a = 1'b1;
    qa.push_back('{L0_3, 1, cyc + 5});
    @(negedge clk);
    req_a = 1'b0;
    wait_idle_a();

    // Latency 3: each word address held for three cycles
    @(negedge clk);
    addr_b = 32'h0; req_b = 1'b1;
    qb.push_back('{L0_3, 1, cyc + 13});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_b = 1'b0;
      chk("b_rom_addr", rom_addr_b, i / 3);
    end
    wait_idle_b();
    repeat (5) @(negedge clk);
    chk("b_hold_data", data_b, L0_3);
    chk("b_hold_rsp", rsp_b, 0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
